// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the WISC instruction-fetch stage.
// State encoding, reset PC, HLT opcode and PC alignment helper.
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    FS_IDLE   = 3'd0,
    FS_FETCH  = 3'd1,
    FS_HOLD   = 3'd2,
    FS_DROP   = 3'd3,
    FS_HALTED = 3'd4
  } fstate_e;

  localparam logic [15:0] RESET_PC_DEF   = 16'h0000;
  localparam logic [3:0]  HLT_OPCODE_DEF = 4'hF;

  function automatic logic [15:0] word_align(
    input logic [15:0] a
  );
    return a & 16'hFFFE;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// WISC fetch stage: owns the PC, issues single-outstanding imem reads
// and presents one buffered instruction to decode over valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [3:0]  HLT_OPCODE = HLT_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_next_i,
  output logic [15:0] pc_q_o,
  output logic        imem_rd_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_rdy_i,
  input  logic [15:0] imem_data_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [15:0] id_instr_o,
  output logic [15:0] id_pc_o,
  input  logic        flush_i,
  input  logic [15:0] flush_pc_i,
  output logic        halted_o,
  output logic [15:0] fetch_cnt_o
);

  fstate_e     state_q;
  logic [15:0] pc_q;
  logic [15:0] addr_q;
  logic [15:0] instr_q;
  logic [15:0] id_pc_q;
  logic [15:0] cnt_q;
  logic        valid_q;
  logic        halted_q;

  logic        accept;
  logic        is_hlt;

  assign accept = valid_q & id_ready_i;
  assign is_hlt = (instr_q[15:12] == HLT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FS_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      instr_q  <= '0;
      id_pc_q  <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        FS_IDLE: begin
          if (flush_i) pc_q <= word_align(flush_pc_i);
          state_q <= FS_FETCH;
        end
        FS_FETCH: begin
          if (flush_i) begin
            pc_q <= word_align(flush_pc_i);
            if (!imem_rdy_i) begin
              // keep the in-flight address on the bus until it retires
              addr_q  <= pc_q;
              state_q <= FS_DROP;
            end
          end else if (imem_rdy_i) begin
            instr_q <= imem_data_i;
            id_pc_q <= pc_q;
            valid_q <= 1'b1;
            state_q <= FS_HOLD;
          end
        end
        FS_DROP: begin
          if (flush_i) pc_q <= word_align(flush_pc_i);
          if (imem_rdy_i) state_q <= FS_FETCH;
        end
        FS_HOLD: begin
          if (accept) cnt_q <= cnt_q + 16'd1;
          if (flush_i) begin
            valid_q <= 1'b0;
            pc_q    <= word_align(flush_pc_i);
            state_q <= FS_FETCH;
          end else if (accept) begin
            valid_q <= 1'b0;
            pc_q    <= word_align(pc_next_i);
            if (is_hlt) begin
              halted_q <= 1'b1;
              state_q  <= FS_HALTED;
            end else begin
              state_q <= FS_FETCH;
            end
          end
        end
        FS_HALTED: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= FS_IDLE;
        end
      endcase
    end
  end

  assign imem_rd_o   = (state_q == FS_FETCH) ||
                       (state_q == FS_DROP);
  assign imem_addr_o = (state_q == FS_DROP) ? addr_q : pc_q;
  assign pc_q_o      = pc_q;
  assign id_valid_o  = valid_q;
  assign id_instr_o  = instr_q;
  assign id_pc_o     = id_pc_q;
  assign halted_o    = halted_q;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Behavioural imem with programmable latency; checks on negedge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pc_next_i = '0;
  logic [15:0] pc_q_o;
  logic        imem_rd_o;
  logic [15:0] imem_addr_o;
  logic        imem_rdy_i = 1'b0;
  logic [15:0] imem_data_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b1;
  logic [15:0] id_instr_o;
  logic [15:0] id_pc_o;
  logic        flush_i = 1'b0;
  logic [15:0] flush_pc_i = '0;
  logic        halted_o;
  logic [15:0] fetch_cnt_o;

  int          checks = 0;
  int          errors = 0;
  int          lat = 0;
  int          wcnt = 0;
  logic        auto_next = 1'b1;
  logic [15:0] hlt_addr = 16'hFFFF;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_next_i   (pc_next_i),
    .pc_q_o      (pc_q_o),
    .imem_rd_o   (imem_rd_o),
    .imem_addr_o (imem_addr_o),
    .imem_rdy_i  (imem_rdy_i),
    .imem_data_i (imem_data_i),
    .id_valid_o  (id_valid_o),
    .id_ready_i  (id_ready_i),
    .id_instr_o  (id_instr_o),
    .id_pc_o     (id_pc_o),
    .flush_i     (flush_i),
    .flush_pc_i  (flush_pc_i),
    .halted_o    (halted_o),
    .fetch_cnt_o (fetch_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == hlt_addr) return 16'hF000;
    return {4'h2, a[11:0] ^ 12'h5A5};
  endfunction

  // imem responder: rdy after lat waiting cycles, driven on negedge
  initial begin
    forever begin
      @(negedge clk);
      if (imem_rdy_i) wcnt = 0;
      if (rst_n && imem_rd_o) begin
        if (wcnt >= lat) begin
          imem_rdy_i  = 1'b1;
          imem_data_i = mem_word(imem_addr_o);
        end else begin
          imem_rdy_i = 1'b0;
          wcnt++;
        end
      end else begin
        imem_rdy_i = 1'b0;
        wcnt = 0;
      end
      if (auto_next) pc_next_i = pc_q_o + 16'd2;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    flush_i    = 1'b0;
    id_ready_i = 1'b1;
    auto_next  = 1'b1;
    lat        = 0;
    hlt_addr   = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_q_o !== 16'h0000) begin
      errors++; $display("FAIL reset_pc got %h exp 0000", pc_q_o);
    end
    checks++;
    if (imem_rd_o !== 1'b0) begin
      errors++; $display("FAIL reset_rd got %b exp 0", imem_rd_o);
    end
    checks++;
    if (id_valid_o !== 1'b0 || halted_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got v=%b h=%b exp 0 0",
               id_valid_o, halted_o);
    end
    checks++;
    if (fetch_cnt_o !== 16'h0 || id_instr_o !== 16'h0 ||
        id_pc_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs got c=%h i=%h p=%h exp 0",
               fetch_cnt_o, id_instr_o, id_pc_o);
    end
  endtask

  task automatic test_stream();
    logic [15:0] a;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      a = 16'(2 * k);
      @(negedge clk);
      checks++;
      if (imem_rd_o !== 1'b1 || imem_addr_o !== a ||
          id_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL stream_fetch got rd=%b a=%h v=%b exp 1 %h 0",
                 imem_rd_o, imem_addr_o, id_valid_o, a);
      end
      @(negedge clk);
      checks++;
      if (id_valid_o !== 1'b1 || id_pc_o !== a ||
          id_instr_o !== mem_word(a) || imem_rd_o !== 1'b0) begin
        errors++;
        $display("FAIL stream_hold got v=%b p=%h i=%h rd=%b exp 1 %h %h 0",
                 id_valid_o, id_pc_o, id_instr_o, imem_rd_o,
                 a, mem_word(a));
      end
      checks++;
      if (fetch_cnt_o !== 16'(k)) begin
        errors++;
        $display("FAIL stream_cnt got %h exp %h", fetch_cnt_o, 16'(k));
      end
    end
    @(negedge clk);
    checks++;
    if (fetch_cnt_o !== 16'd3 || pc_q_o !== 16'h0006) begin
      errors++;
      $display("FAIL stream_end got c=%h pc=%h exp 0003 0006",
               fetch_cnt_o, pc_q_o);
    end
  endtask

  task automatic test_delay();
    apply_reset();
    lat = 3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0 ||
          id_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL delay_hold%0d got rd=%b a=%h v=%b exp 1 0000 0",
                 i, imem_rd_o, imem_addr_o, id_valid_o);
      end
    end
    @(negedge clk);
    checks++;
    if (id_valid_o !== 1'b1 || id_instr_o !== mem_word(16'h0)) begin
      errors++;
      $display("FAIL delay_valid got v=%b i=%h exp 1 %h",
               id_valid_o, id_instr_o, mem_word(16'h0));
    end
  endtask

  task automatic test_stall();
    apply_reset();
    id_ready_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (id_valid_o !== 1'b1 || id_pc_o !== 16'h0 ||
          id_instr_o !== mem_word(16'h0) || imem_rd_o !== 1'b0 ||
          fetch_cnt_o !== 16'h0) begin
        errors++;
        $display("FAIL stall%0d got v=%b p=%h i=%h rd=%b c=%h",
                 i, id_valid_o, id_pc_o, id_instr_o, imem_rd_o,
                 fetch_cnt_o);
      end
    end
    auto_next  = 1'b0;
    pc_next_i  = 16'h0011;
    id_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (id_valid_o !== 1'b0 || pc_q_o !== 16'h0010 ||
        fetch_cnt_o !== 16'h1 || imem_rd_o !== 1'b1 ||
        imem_addr_o !== 16'h0010) begin
      errors++;
      $display("FAIL stall_release got v=%b pc=%h c=%h rd=%b a=%h exp 0 0010 0001 1 0010",
               id_valid_o, pc_q_o, fetch_cnt_o, imem_rd_o, imem_addr_o);
    end
  endtask

  task automatic test_drop();
    apply_reset();
    lat = 3;
    @(negedge clk);
    flush_i    = 1'b1;
    flush_pc_i = 16'h0041;
    @(negedge clk);
    flush_i = 1'b0;
    checks++;
    if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0 ||
        pc_q_o !== 16'h0040 || id_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_enter got rd=%b a=%h pc=%h v=%b exp 1 0000 0040 0",
               imem_rd_o, imem_addr_o, pc_q_o, id_valid_o);
    end
    @(negedge clk);
    @(negedge clk);
    lat = 0;
    checks++;
    if (imem_addr_o !== 16'h0 || id_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_wait got a=%h v=%b exp 0000 0",
               imem_addr_o, id_valid_o);
    end
    @(negedge clk);
    checks++;
    if (imem_rd_o !== 1'b1 || imem_addr_o !== 16'h0040 ||
        id_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drop_refetch got rd=%b a=%h v=%b exp 1 0040 0",
               imem_rd_o, imem_addr_o, id_valid_o);
    end
    @(negedge clk);
    checks++;
    if (id_valid_o !== 1'b1 || id_pc_o !== 16'h0040 ||
        id_instr_o !== mem_word(16'h0040)) begin
      errors++;
      $display("FAIL drop_word got v=%b p=%h i=%h exp 1 0040 %h",
               id_valid_o, id_pc_o, id_instr_o, mem_word(16'h0040));
    end
  endtask

  task automatic test_halt();
    apply_reset();
    hlt_addr  = 16'h0000;
    auto_next = 1'b0;
    pc_next_i = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (id_valid_o !== 1'b1 || id_instr_o !== 16'hF000) begin
      errors++;
      $display("FAIL halt_hold got v=%b i=%h exp 1 f000",
               id_valid_o, id_instr_o);
    end
    @(negedge clk);
    checks++;
    if (halted_o !== 1'b1 || id_valid_o !== 1'b0 ||
        imem_rd_o !== 1'b0 || fetch_cnt_o !== 16'h1) begin
      errors++;
      $display("FAIL halt_enter got h=%b v=%b rd=%b c=%h exp 1 0 0 0001",
               halted_o, id_valid_o, imem_rd_o, fetch_cnt_o);
    end
    flush_i    = 1'b1;
    flush_pc_i = 16'h0080;
    @(negedge clk);
    flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (halted_o !== 1'b1 || imem_rd_o !== 1'b0 ||
          pc_q_o !== 16'h0 || id_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL halt_park%0d got h=%b rd=%b pc=%h v=%b exp 1 0 0000 0",
                 i, halted_o, imem_rd_o, pc_q_o, id_valid_o);
      end
    end
  endtask

  task automatic test_hlt_flush();
    apply_reset();
    hlt_addr = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    flush_i    = 1'b1;
    flush_pc_i = 16'h0020;
    @(negedge clk);
    flush_i = 1'b0;
    checks++;
    if (halted_o !== 1'b0 || imem_rd_o !== 1'b1 ||
        imem_addr_o !== 16'h0020 || fetch_cnt_o !== 16'h1 ||
        id_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hltflush got h=%b rd=%b a=%h c=%h v=%b exp 0 1 0020 0001 0",
               halted_o, imem_rd_o, imem_addr_o, fetch_cnt_o, id_valid_o);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    @(negedge clk);
    checks++;
    if (fetch_cnt_o !== 16'h0000 || pc_q_o !== 16'h0002) begin
      errors++;
      $display("FAIL wrap got c=%h pc=%h exp 0000 0002",
               fetch_cnt_o, pc_q_o);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_delay();
    test_stall();
    test_drop();
    test_halt();
    test_hlt_flush();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
